brightness_plane_sequencer: RTL and testbench

- Upstream driver of `brightness_timeout`. Produces the `row_latch` pulse, `brightness_mask_active` and `row_address` that the timeout block consumes.
- Steps through bit-planes MSB to LSB for each row, and rows 0 to PIXEL_ROWS-1 per frame.
- Coordinates the column shifter through a start/done handshake.
- Never latches a new plane while the previous plane's display window is still inside its guaranteed time. It waits on the timeout block's `output_enable` / `exceeded_overlap_time` before latching.

---
 rtl/brightness_plane_sequencer.sv | 97 +++++++++
 tb/tb_brightness_plane_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brightness_plane_sequencer.sv
// rtl/brightness_plane_sequencer.sv - bit-plane/row scan sequencer feeding brightness_timeout
// Shifts each plane MSB->LSB per row, then latches it once the previous plane's window allows.

package params_pkg;
  localparam int BRIGHTNESS_LEVELS = 8;
endpackage

module brightness_plane_sequencer #(
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int PIXEL_ROWS        = 16,
  parameter int ROW_BITS          = $clog2(PIXEL_ROWS)
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         shift_start,
  input  logic                         shift_done,
  output logic [BRIGHTNESS_LEVELS-1:0] shift_mask,
  output logic [ROW_BITS-1:0]          shift_row,
  input  logic                         output_enable,
  input  logic                         exceeded_overlap_time,
  output logic                         row_latch,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
  output logic [ROW_BITS-1:0]          row_address,
  output logic                         frame_done,
  output logic                         busy
);

  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_MSB =
    BRIGHTNESS_LEVELS'(1) << (BRIGHTNESS_LEVELS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(PIXEL_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SHIFT_WAIT,
    DISPLAY_WAIT,
    LATCH
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (enable) state_next = SHIFT;
      SHIFT:        state_next = SHIFT_WAIT;
      SHIFT_WAIT:   if (shift_done) state_next = DISPLAY_WAIT;
      // Previous plane must have met its minimum on-time, or already be dark.
      DISPLAY_WAIT: if (exceeded_overlap_time || !output_enable) state_next = LATCH;
      LATCH:        state_next = enable ? SHIFT : IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Outputs decode the state being entered so they line up with that state.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      shift_start            <= 1'b0;
      row_latch              <= 1'b0;
      frame_done             <= 1'b0;
      busy                   <= 1'b0;
      brightness_mask_active <= '0;
      row_address            <= '0;
      shift_row              <= '0;
      shift_mask             <= MASK_MSB;
    end else begin
      shift_start <= (state_next == SHIFT);
      row_latch   <= (state_next == LATCH);
      busy        <= (state_next != IDLE);
      frame_done  <= (state_next == LATCH) && shift_mask[0] && (shift_row == ROW_LAST);
      if (state_next == LATCH) begin
        brightness_mask_active <= shift_mask;
        row_address            <= shift_row;
      end
      // Pointer advances on the edge leaving LATCH; it is kept while parked in IDLE.
      if (state == LATCH) begin
        if (shift_mask[0]) begin
          shift_mask <= MASK_MSB;
          shift_row  <= (shift_row == ROW_LAST) ? '0 : shift_row + ROW_BITS'(1);
        end else begin
          shift_mask <= shift_mask >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_brightness_plane_sequencer.sv
// tb/tb_brightness_plane_sequencer.sv - scoreboard bench for brightness_plane_sequencer
module tb_brightness_plane_sequencer;

  localparam int B  = 3;
  localparam int R  = 2;
  localparam int RB = 1;

  logic          clk_in;
  logic          reset;
  logic          enable;
  logic          shift_start;
  logic          shift_done;
  logic [B-1:0]  shift_mask;
  logic [RB-1:0] shift_row;
  logic          output_enable;
  logic          exceeded_overlap_time;
  logic          row_latch;
  logic [B-1:0]  brightness_mask_active;
  logic [RB-1:0] row_address;
  logic          frame_done;
  logic          busy;

  brightness_plane_sequencer #(
    .BRIGHTNESS_LEVELS(B),
    .PIXEL_ROWS(R)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .shift_start(shift_start),
    .shift_done(shift_done),
    .shift_mask(shift_mask),
    .shift_row(shift_row),
    .output_enable(output_enable),
    .exceeded_overlap_time(exceeded_overlap_time),
    .row_latch(row_latch),
    .brightness_mask_active(brightness_mask_active),
    .row_address(row_address),
    .frame_done(frame_done),
    .busy(busy)
  );

  typedef struct {
    logic [B-1:0]  mask;
    logic [RB-1:0] row;
    logic          fd;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_latch = 0;
  int   n_ss = 0;
  int   tmo_mode = 0;
  logic inj = 1'b0;
  logic hold_oe = 1'b0;
  logic hold_exc = 1'b0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // k-th latch after reset: planes MSB..LSB, rows 0..R-1, frame ends on last plane of last row.
  function automatic exp_t model(input int k);
    exp_t e;
    e.mask = B'(1 << (B - 1 - (k % B)));
    e.row  = RB'((k / B) % R);
    e.fd   = ((k % (B * R)) == (B * R - 1));
    e.due  = -1;
    return e;
  endfunction

  // Shifter stub and display-window model.
  initial begin
    int   sd_cnt;
    int   k_sh;
    int   tm;
    int   plane;
    logic win;
    logic inj_pend;
    exp_t e;
    sd_cnt = 0; k_sh = 0; tm = 0; plane = 0; win = 1'b0; inj_pend = 1'b0;
    shift_done = 1'b0;
    output_enable = 1'b0;
    exceeded_overlap_time = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      shift_done = 1'b0;
      if (reset) begin
        sd_cnt = 0;
        k_sh = 0;
        inj_pend = 1'b0;
        exp_q.delete();
      end else begin
        if (sd_cnt > 0) begin
          sd_cnt--;
          if (sd_cnt == 0) begin
            shift_done = 1'b1;
            inj_pend = inj;
            if (tmo_mode == 0 && exp_q.size() > 0) begin
              e = exp_q.pop_back();
              e.due = cyc + 2;
              exp_q.push_back(e);
            end
          end
        end else if (inj_pend) begin
          shift_done = 1'b1;
          inj_pend = 1'b0;
        end
        if (shift_start) begin
          e = model(k_sh);
          check("shift_mask", shift_mask, e.mask);
          check("shift_row", shift_row, e.row);
          exp_q.push_back(e);
          k_sh++;
          sd_cnt = 3;
          if (inj) shift_done = 1'b1;
        end
      end
      if (tmo_mode == 1) begin
        win = 1'b0;
        output_enable = hold_oe;
        exceeded_overlap_time = hold_exc;
      end else if (tmo_mode == 2) begin
        if (row_latch) begin
          win = 1'b1;
          tm = 0;
          for (int i = 0; i < B; i++) if (brightness_mask_active[i]) plane = i;
        end
        if (win) begin
          tm++;
          if (tm >= (6 << plane)) win = 1'b0;
        end
        output_enable = win;
        exceeded_overlap_time = win && (tm >= (2 << plane));
      end else begin
        win = 1'b0;
        output_enable = 1'b0;
        exceeded_overlap_time = 1'b0;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each row_latch.
  initial begin
    logic prev_ok;
    exp_t e;
    prev_ok = 1'b1;
    forever begin
      @(negedge clk_in);
      check("latch_and_start", row_latch & shift_start, 0);
      check("shift_mask_onehot", $onehot(shift_mask), 1);
      check("mask_active_onehot0", $onehot0(brightness_mask_active), 1);
      check("frame_done_alone", frame_done & ~row_latch, 0);
      if (shift_start) n_ss++;
      if (row_latch) begin
        n_latch++;
        check("latch_window", prev_ok, 1);
        if (exp_q.size() == 0) begin
          check("extra_latch", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latch_mask", brightness_mask_active, e.mask);
          check("latch_row", row_address, e.row);
          check("frame_done", frame_done, e.fd);
          if (e.due >= 0) check("latch_cycle", cyc, e.due);
        end
      end
      prev_ok = !output_enable || exceeded_overlap_time;
    end
  end

  task automatic sample();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_latches(input int target, input int budget);
    int n = 0;
    while (n_latch < target && n < budget) begin
      sample();
      n++;
    end
    check("wait_latches", n_latch >= target, 1);
  endtask

  task automatic wait_cond(input int what, input string name);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 400) begin
      sample();
      n++;
      case (what)
        0: hit = shift_start && shift_mask == 3'b010;
        1: hit = shift_done;
        2: hit = shift_start;
        3: hit = shift_start && shift_row == 1'b1;
        default: hit = !busy;
      endcase
    end
    check(name, hit, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_shift_start", shift_start, 0);
    check("rst_row_latch", row_latch, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_mask_active", brightness_mask_active, 0);
    check("rst_row_address", row_address, 0);
    check("rst_shift_row", shift_row, 0);
    check("rst_shift_mask", shift_mask, 3'b100);
  endtask

  initial begin
    int   base;
    int   ss0;
    logic saw;
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // Two frames with the shifter answering 3 cycles after each start.
    @(posedge clk_in);
    #1;
    enable = 1'b1;
    check("start_before", shift_start, 0);
    @(posedge clk_in);
    #1;
    check("start_latency", shift_start, 1);
    check("busy_running", busy, 1);
    wait_latches(12, 600);

    // Display window held open: no latch until exceeded_overlap_time rises.
    @(posedge clk_in);
    hold_oe = 1'b1;
    hold_exc = 1'b0;
    tmo_mode = 1;
    wait_cond(1, "hold_shift_done");
    saw = 1'b0;
    repeat (20) begin
      sample();
      if (row_latch) saw = 1'b1;
    end
    check("hold_no_latch", saw, 0);
    @(posedge clk_in);
    hold_exc = 1'b1;
    sample();
    check("exc_cycle1", row_latch, 0);
    sample();
    check("exc_cycle2", row_latch, 1);
    @(posedge clk_in);
    hold_exc = 1'b0;
    hold_oe = 1'b0;
    tmo_mode = 0;

    // Spurious shift_done in SHIFT and DISPLAY_WAIT.
    inj = 1'b1;
    base = n_latch;
    wait_latches(base + 12, 600);
    inj = 1'b0;

    // Drop enable mid-shift of plane 010, then resume.
    wait_cond(0, "find_plane_010");
    @(posedge clk_in);
    #1;
    enable = 1'b0;
    ss0 = n_ss;
    base = n_latch;
    wait_latches(base + 1, 100);
    repeat (10) sample();
    check("parked_busy", busy, 0);
    check("parked_no_start", n_ss, ss0);
    check("parked_mask_hold", brightness_mask_active, 3'b010);
    @(posedge clk_in);
    #1;
    enable = 1'b1;
    wait_cond(2, "resume_start");
    check("resume_mask", shift_mask, 3'b001);

    // Reset while stalled in DISPLAY_WAIT on row 1.
    wait_cond(3, "find_row1");
    @(posedge clk_in);
    hold_oe = 1'b1;
    hold_exc = 1'b0;
    tmo_mode = 1;
    wait_cond(1, "row1_shift_done");
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check_reset_vals();
    @(posedge clk_in);
    tmo_mode = 2;
    #1;
    reset = 1'b0;

    // Two frames against the display-window model.
    base = n_latch;
    wait_latches(base + 12, 3000);
    @(posedge clk_in);
    #1;
    enable = 1'b0;
    wait_cond(4, "final_idle");
    repeat (2) sample();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
